// File: rtl/gpmc_master.sv
// GPMC-style muxed address/data bus master: one transaction at a time, split into
// address, data and recovery phases, each a fixed number of clk cycles.
module gpmc_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_CYC   = 2,
  parameter int DATA_CYC   = 4,
  parameter int RECOV_CYC  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [DATA_WIDTH-1:0] gpmc_ad_out,
  output logic                  gpmc_ad_oe,
  input  logic [DATA_WIDTH-1:0] gpmc_ad_in,
  output logic                  gpmc_advn,
  output logic                  gpmc_csn1,
  output logic                  gpmc_wein,
  output logic                  gpmc_oen,
  output logic                  gpmc_clk
);

  localparam int MAX_AD = (ADDR_CYC > DATA_CYC) ? ADDR_CYC : DATA_CYC;
  localparam int MAXC   = (MAX_AD > RECOV_CYC) ? MAX_AD : RECOV_CYC;
  localparam int CW     = $clog2(MAXC + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADDR  = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_RECOV = 2'd3;

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  logic [1:0]            state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  req_t                  req_q, req_n;
  logic                  accept;
  logic                  ready_n, rsp_n, oe_n, advn_n, csn_n, wein_n, oen_n, gclk_n;
  logic [DATA_WIDTH-1:0] rdata_n, ad_n;

  assign accept = req_valid && req_ready;

  // Next-state and phase counter
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    req_n   = req_q;
    case (state)
      S_IDLE: if (accept) begin
        state_n = S_ADDR;
        cnt_n   = CW'(ADDR_CYC - 1);
        req_n   = '{wr: req_write, addr: req_addr, wdata: req_wdata};
      end
      S_ADDR: if (cnt == '0) begin
        state_n = S_DATA;
        cnt_n   = CW'(DATA_CYC - 1);
      end else cnt_n = cnt - CW'(1);
      S_DATA: if (cnt == '0) begin
        state_n = S_RECOV;
        cnt_n   = CW'(RECOV_CYC - 1);
      end else cnt_n = cnt - CW'(1);
      S_RECOV: if (cnt == '0) begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end else cnt_n = cnt - CW'(1);
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so every pin comes straight off a flop;
  // oe and oen change on the same edge, so the bus is never driven against the device.
  always_comb begin
    ready_n = (state_n == S_IDLE);
    csn_n   = 1'b1;
    advn_n  = 1'b1;
    wein_n  = 1'b1;
    oen_n   = 1'b1;
    oe_n    = 1'b0;
    ad_n    = '0;
    gclk_n  = 1'b0;
    case (state_n)
      S_ADDR: begin
        csn_n  = 1'b0;
        advn_n = 1'b0;
        oe_n   = 1'b1;
        ad_n   = DATA_WIDTH'(req_n.addr);
        gclk_n = (state == S_IDLE) ? 1'b0 : ~gpmc_clk;
      end
      S_DATA: begin
        csn_n  = 1'b0;
        gclk_n = ~gpmc_clk;
        if (req_n.wr) begin
          wein_n = 1'b0;
          oe_n   = 1'b1;
          ad_n   = req_n.wdata;
        end else begin
          oen_n  = 1'b0;
        end
      end
      default: ;
    endcase
    rsp_n   = (state == S_DATA) && (state_n == S_RECOV);
    rdata_n = rsp_rdata;
    if (rsp_n) rdata_n = req_q.wr ? '0 : gpmc_ad_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      req_q       <= '0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      gpmc_ad_out <= '0;
      gpmc_ad_oe  <= 1'b0;
      gpmc_advn   <= 1'b1;
      gpmc_csn1   <= 1'b1;
      gpmc_wein   <= 1'b1;
      gpmc_oen    <= 1'b1;
      gpmc_clk    <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      req_q       <= req_n;
      req_ready   <= ready_n;
      rsp_valid   <= rsp_n;
      rsp_rdata   <= rdata_n;
      gpmc_ad_out <= ad_n;
      gpmc_ad_oe  <= oe_n;
      gpmc_advn   <= advn_n;
      gpmc_csn1   <= csn_n;
      gpmc_wein   <= wein_n;
      gpmc_oen    <= oen_n;
      gpmc_clk    <= gclk_n;
    end
  end

endmodule

// File: tb/tb_gpmc_master.sv
// Directed bench for gpmc_master: default timing instance plus a 1/1/1 timing instance.
module tb_gpmc_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // instance A: default timing
  logic        val_a = 0, wr_a = 0, rdy_a, rv_a, oe_a, advn_a, csn_a, wein_a, oen_a, gclk_a;
  logic [3:0]  addr_a = 0;
  logic [15:0] wd_a = 0, adin_a = 16'hDEAD, rd_a, ad_a;
  // instance B: one cycle per phase
  logic        val_b = 0, wr_b = 0, rdy_b, rv_b, oe_b, advn_b, csn_b, wein_b, oen_b, gclk_b;
  logic [3:0]  addr_b = 0;
  logic [15:0] wd_b = 0, adin_b = 16'hDEAD, rd_b, ad_b;

  logic [7:0] ctl_a, ctl_b;
  assign ctl_a = {rdy_a, rv_a, csn_a, advn_a, wein_a, oen_a, oe_a, gclk_a};
  assign ctl_b = {rdy_b, rv_b, csn_b, advn_b, wein_b, oen_b, oe_b, gclk_b};

  gpmc_master u_a (
    .clk(clk), .rst(rst), .req_valid(val_a), .req_ready(rdy_a), .req_write(wr_a),
    .req_addr(addr_a), .req_wdata(wd_a), .rsp_valid(rv_a), .rsp_rdata(rd_a),
    .gpmc_ad_out(ad_a), .gpmc_ad_oe(oe_a), .gpmc_ad_in(adin_a), .gpmc_advn(advn_a),
    .gpmc_csn1(csn_a), .gpmc_wein(wein_a), .gpmc_oen(oen_a), .gpmc_clk(gclk_a));

  gpmc_master #(.ADDR_CYC(1), .DATA_CYC(1), .RECOV_CYC(1)) u_b (
    .clk(clk), .rst(rst), .req_valid(val_b), .req_ready(rdy_b), .req_write(wr_b),
    .req_addr(addr_b), .req_wdata(wd_b), .rsp_valid(rv_b), .rsp_rdata(rd_b),
    .gpmc_ad_out(ad_b), .gpmc_ad_oe(oe_b), .gpmc_ad_in(adin_b), .gpmc_advn(advn_b),
    .gpmc_csn1(csn_b), .gpmc_wein(wein_b), .gpmc_oen(oen_b), .gpmc_clk(gclk_b));

  // Expected {ready, rsp_valid, csn1, advn, wein, oen, ad_oe, gpmc_clk} in cycle n after accept
  function automatic logic [7:0] exp_ctl(int n, bit wr, int a, int d, int r);
    logic g;
    g = 1'((n - 1) % 2);
    if (n <= 0 || n > a + d + r) return 8'b1011_1100;
    if (n <= a)                  return {7'b0000_111, g};
    if (n <= a + d)              return wr ? {7'b0001_011, g} : {7'b0001_100, g};
    return {1'b0, 1'(n == a + d + 1), 6'b1111_00};
  endfunction

  function automatic logic [15:0] exp_ad(int n, bit wr, logic [3:0] ad, logic [15:0] wd, int a, int d);
    if (n >= 1 && n <= a)         return {12'h000, ad};
    if (n > a && n <= a + d && wr) return wd;
    return 16'h0000;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(string tg, int n, bit wr, logic [3:0] ad, logic [15:0] wd);
    chk($sformatf("%s_ctl%0d", tg, n), 32'(ctl_a), 32'(exp_ctl(n, wr, 2, 4, 2)));
    chk($sformatf("%s_ad%0d", tg, n), 32'(ad_a), 32'(exp_ad(n, wr, ad, wd, 2, 4)));
  endtask

  task automatic chk_b(string tg, int n, bit wr, logic [3:0] ad, logic [15:0] wd);
    chk($sformatf("%s_ctl%0d", tg, n), 32'(ctl_b), 32'(exp_ctl(n, wr, 1, 1, 1)));
    chk($sformatf("%s_ad%0d", tg, n), 32'(ad_b), 32'(exp_ad(n, wr, ad, wd, 1, 1)));
  endtask

  initial begin
    // reset
    rst = 1; step(); step(); rst = 0;
    chk("rst_ctl_a", 32'(ctl_a), 32'(8'b1011_1100));
    chk("rst_ad_a", 32'(ad_a), 32'h0);
    chk("rst_rd_a", 32'(rd_a), 32'h0);
    chk("rst_ctl_b", 32'(ctl_b), 32'(8'b1011_1100));

    // read addr 5; bus carries 0x1234 only in the last data cycle
    val_a = 1; wr_a = 0; addr_a = 4'h5; step(); val_a = 0;
    for (int n = 1; n <= 9; n++) begin
      chk_a("rd", n, 0, 4'h5, 16'h0);
      if (n == 7 || n == 9) chk($sformatf("rd_rdata%0d", n), 32'(rd_a), 32'h1234);
      adin_a = (n == 6) ? 16'h1234 : 16'hDEAD;
      step();
    end

    // write addr 3, 0xBEEF
    val_a = 1; wr_a = 1; addr_a = 4'h3; wd_a = 16'hBEEF; step(); val_a = 0;
    for (int n = 1; n <= 9; n++) begin
      chk_a("wr", n, 1, 4'h3, 16'hBEEF);
      if (n == 7) chk("wr_rdata", 32'(rd_a), 32'h0);
      step();
    end

    // req_valid held high across two writes
    val_a = 1; wr_a = 1; addr_a = 4'h1; wd_a = 16'h00AA; step();
    for (int n = 1; n <= 9; n++) begin
      chk_a("b2b1", n, 1, 4'h1, 16'h00AA);
      if (n == 9) begin addr_a = 4'h2; wd_a = 16'h0055; end
      step();
    end
    for (int n = 1; n <= 9; n++) begin
      chk_a("b2b2", n, 1, 4'h2, 16'h0055);
      if (n == 1) val_a = 0;
      step();
    end
    chk("b2b_idle", 32'(ctl_a), 32'(8'b1011_1100));

    // reset in the middle of a read
    val_a = 1; wr_a = 0; addr_a = 4'h5; adin_a = 16'h1234; step(); val_a = 0;
    for (int n = 1; n <= 4; n++) begin
      chk_a("abort", n, 0, 4'h5, 16'h0);
      if (n == 4) rst = 1;
      step();
    end
    rst = 0;
    chk("abort_ad", 32'(ad_a), 32'h0);
    chk("abort_rd", 32'(rd_a), 32'h0);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("abort_idle%0d", k), 32'(ctl_a), 32'(8'b1011_1100));
      step();
    end

    // reset wins over simultaneous request
    rst = 1; val_a = 1; wr_a = 1; addr_a = 4'hF; wd_a = 16'hFFFF; step();
    rst = 0; val_a = 0;
    chk("rstreq_ctl0", 32'(ctl_a), 32'(8'b1011_1100));
    chk("rstreq_ad0", 32'(ad_a), 32'h0);
    step();
    chk("rstreq_ctl1", 32'(ctl_a), 32'(8'b1011_1100));

    // 1/1/1 timing, back-to-back read then write
    val_b = 1; wr_b = 0; addr_b = 4'h9; adin_b = 16'h0F0F; step();
    for (int n = 1; n <= 4; n++) begin
      chk_b("bb_rd", n, 0, 4'h9, 16'h0);
      if (n == 3) chk("bb_rdata", 32'(rd_b), 32'h0F0F);
      if (n == 4) begin wr_b = 1; addr_b = 4'h7; wd_b = 16'h5A5A; end
      step();
    end
    for (int n = 1; n <= 4; n++) begin
      chk_b("bb_wr", n, 1, 4'h7, 16'h5A5A);
      if (n == 1) val_b = 0;
      if (n == 3) chk("bb_wrdata", 32'(rd_b), 32'h0);
      step();
    end
    chk("bb_idle", 32'(ctl_b), 32'(8'b1011_1100));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
